// File: rtl/proc_pkg.sv
// ============================================================================
// proc_pkg: shared opcodes, IR field positions and state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package proc_pkg;

  localparam int NREG = 4;
  localparam int IR_W = 7;

  localparam int OP_HI = 6;
  localparam int OP_LO = 4;
  localparam int X_HI  = 3;
  localparam int X_LO  = 2;
  localparam int Y_HI  = 1;
  localparam int Y_LO  = 0;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/proc_dec2to4.sv
// ============================================================================
// proc_dec2to4: 2-bit index to one-hot-4 decoder with enable
// Rev 1.0
// ============================================================================
`default_nettype none

module proc_dec2to4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/proc_control_fsm.sv
// ============================================================================
// proc_control_fsm: T0-T3 multicycle control unit for the 4-register datapath
// Rev 1.0
// ============================================================================
`default_nettype none

module proc_control_fsm #(
  parameter int DATA_W = 16,
  parameter int NREG   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  output logic              ir_in,
  output logic [NREG-1:0]   r_in,
  output logic [NREG-1:0]   r_out,
  output logic              din_out,
  output logic              a_in,
  output logic              g_in,
  output logic              g_out,
  output logic              add_sub,
  output logic              done,
  output logic              busy
);

  import proc_pkg::*;

  state_t           state_q, state_d;
  logic [IR_W-1:0]  ir_q, ir_d;

  logic [2:0] w_op;
  logic [1:0] w_x;
  logic [1:0] w_y;
  logic       w_rin_en;
  logic       w_rout_en;
  logic       w_rout_sel_y;
  logic [1:0] w_rout_sel;

  assign w_op = ir_q[OP_HI:OP_LO];
  assign w_x  = ir_q[X_HI:X_LO];
  assign w_y  = ir_q[Y_HI:Y_LO];

  generate
    if (DATA_W > IR_W) begin : g_unused_din
      logic unused_din_hi;
      assign unused_din_hi = ^din[DATA_W-1:IR_W];
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    ir_in        = 1'b0;
    din_out      = 1'b0;
    a_in         = 1'b0;
    g_in         = 1'b0;
    g_out        = 1'b0;
    add_sub      = 1'b0;
    done         = 1'b0;
    w_rin_en     = 1'b0;
    w_rout_en    = 1'b0;
    w_rout_sel_y = 1'b0;

    case (state_q)
      T0: begin
        // Gating with reset keeps ir_in low while reset is held with run high.
        if (run && !reset) begin
          ir_in   = 1'b1;
          ir_d    = din[IR_W-1:0];
          state_d = T1;
        end
      end
      T1: begin
        case (w_op)
          OP_MV: begin
            w_rout_en    = 1'b1;
            w_rout_sel_y = 1'b1;
            w_rin_en     = 1'b1;
            done         = 1'b1;
            state_d      = T0;
          end
          OP_MVI: begin
            din_out  = 1'b1;
            w_rin_en = 1'b1;
            done     = 1'b1;
            state_d  = T0;
          end
          OP_ADD, OP_SUB: begin
            w_rout_en = 1'b1;
            a_in      = 1'b1;
            state_d   = T2;
          end
          default: begin
            done    = 1'b1;
            state_d = T0;
          end
        endcase
      end
      T2: begin
        w_rout_en    = 1'b1;
        w_rout_sel_y = 1'b1;
        g_in         = 1'b1;
        add_sub      = (w_op == OP_SUB);
        state_d      = T3;
      end
      T3: begin
        g_out    = 1'b1;
        w_rin_en = 1'b1;
        done     = 1'b1;
        state_d  = T0;
      end
      default: state_d = T0;
    endcase
  end

  assign busy       = (state_q != T0);
  assign w_rout_sel = w_rout_sel_y ? w_y : w_x;

  proc_dec2to4 u_dec_rin (
    .en     (w_rin_en),
    .sel    (w_x),
    .onehot (r_in)
  );

  proc_dec2to4 u_dec_rout (
    .en     (w_rout_en),
    .sel    (w_rout_sel),
    .onehot (r_out)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_proc_control_fsm.sv
// Directed bench: per-instruction expected output sequences from the ISA rules,
// compared every cycle, plus literal pins and a bus-exclusivity check.
`default_nettype none

module tb_proc_control_fsm;

  typedef struct packed {
    logic       ir_in;
    logic [3:0] r_in;
    logic [3:0] r_out;
    logic       din_out;
    logic       a_in;
    logic       g_in;
    logic       g_out;
    logic       add_sub;
    logic       done;
    logic       busy;
  } outs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] din;
  logic        ir_in, din_out, a_in, g_in, g_out, add_sub, done, busy;
  logic [3:0]  r_in, r_out;

  proc_control_fsm #(.DATA_W(16), .NREG(4)) dut (
    .clock   (clk),
    .reset   (reset),
    .run     (run),
    .din     (din),
    .ir_in   (ir_in),
    .r_in    (r_in),
    .r_out   (r_out),
    .din_out (din_out),
    .a_in    (a_in),
    .g_in    (g_in),
    .g_out   (g_out),
    .add_sub (add_sub),
    .done    (done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  outs_t act;
  assign act = '{ir_in, r_in, r_out, din_out, a_in, g_in, g_out, add_sub, done, busy};

  int    checks = 0;
  int    passes = 0;
  int    cyc    = 0;
  bit    active = 1'b0;
  outs_t expq[$];
  outs_t hist [0:1023];
  outs_t mseq [4];
  int    mlen;

  function automatic outs_t rec(input logic ir, input logic [3:0] ri, input logic [3:0] ro,
                                input logic dout, input logic ain, input logic gin,
                                input logic gout, input logic asub, input logic dn,
                                input logic bz);
    return '{ir, ri, ro, dout, ain, gin, gout, asub, dn, bz};
  endfunction

  // Expected cycle-by-cycle outputs for one instruction, starting at its fetch cycle.
  task automatic model_seq(input logic [15:0] w);
    logic [2:0] op;
    logic [3:0] rx, ry;
    op = w[6:4];
    rx = 4'b0001 << w[3:2];
    ry = 4'b0001 << w[1:0];
    mseq[0] = rec(1, 4'b0, 4'b0, 0, 0, 0, 0, 0, 0, 0);
    mlen = 2;
    case (op)
      3'd0: mseq[1] = rec(0, rx, ry, 0, 0, 0, 0, 0, 1, 1);
      3'd1: mseq[1] = rec(0, rx, 4'b0, 1, 0, 0, 0, 0, 1, 1);
      3'd2, 3'd3: begin
        mseq[1] = rec(0, 4'b0, rx, 0, 1, 0, 0, 0, 0, 1);
        mseq[2] = rec(0, 4'b0, ry, 0, 0, 1, 0, (op == 3'd3), 0, 1);
        mseq[3] = rec(0, rx, 4'b0, 0, 0, 0, 1, 0, 1, 1);
        mlen = 4;
      end
      default: mseq[1] = rec(0, 4'b0, 4'b0, 0, 0, 0, 0, 0, 1, 1);
    endcase
  endtask

  task automatic lit(input string name, input outs_t got, input outs_t exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passes++;
  endtask

  always @(negedge clk) begin
    outs_t exp;
    int    nb;
    if (active) begin
      exp = (expq.size() > 0) ? expq.pop_front() : '0;
      hist[cyc] = act;
      checks++;
      if (act !== exp) $display("FAIL outputs cyc %0d: got %h expected %h", cyc, act, exp);
      else passes++;
      nb = $countones(act.r_out) + int'(act.din_out) + int'(act.g_out);
      checks++;
      if (nb > 1 || !$onehot0(act.r_in))
        $display("FAIL bus_rule cyc %0d: got r_out=%b din_out=%b g_out=%b r_in=%b expected at most one driver and one-hot r_in",
                 cyc, act.r_out, act.din_out, act.g_out, act.r_in);
      else passes++;
      cyc++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      run = 1'b0; din = 16'h0000;
      expq.push_back('0);
    end
  endtask

  // run is held high through T1-T3 on purpose: it must be ignored there.
  task automatic instr(input logic [15:0] w, input logic [15:0] imm, output int start);
    @(posedge clk); #1;
    start = cyc;
    model_seq(w);
    for (int k = 0; k < mlen; k++) expq.push_back(mseq[k]);
    run = 1'b1; din = w;
    for (int k = 1; k < mlen; k++) begin
      @(posedge clk); #1;
      run = 1'b1;
      din = (k == 1) ? imm : 16'hA5A5;
    end
  endtask

  int s_idle, s_mvi, s_add, s_sub, s_mv, s_nop, s_rst, s_mv11, s_tmp;
  logic [15:0] extra [3] = '{16'h002F, 16'h0034, 16'h001C};

  initial begin
    reset = 1'b1; run = 1'b0; din = 16'h0000;
    active = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      run = 1'b1; din = 16'h0014;
      expq.push_back('0);
    end
    @(posedge clk); #1;
    reset = 1'b0; run = 1'b0; din = 16'h0000;
    expq.push_back('0);
    s_idle = cyc;
    idle(5);

    instr(16'h0014, 16'h0025, s_mvi);
    idle(1);
    instr(16'h0021, 16'h0000, s_add);
    idle(2);
    instr(16'h003E, 16'h0000, s_sub);
    instr(16'h000B, 16'h0000, s_mv);
    idle(1);
    instr(16'h0070, 16'h0000, s_nop);
    idle(1);
    foreach (extra[i]) begin
      instr(extra[i], 16'h1234, s_tmp);
    end
    idle(1);

    // Reset asserted during T2 of add R0,R1.
    @(posedge clk); #1;
    s_rst = cyc;
    model_seq(16'h0021);
    expq.push_back(mseq[0]);
    run = 1'b1; din = 16'h0021;
    @(posedge clk); #1;
    expq.push_back(mseq[1]);
    @(posedge clk); #1;
    lit("pre_reset_T2", act, rec(0, 4'b0, 4'b0010, 0, 0, 1, 0, 0, 0, 1));
    reset = 1'b1;
    expq.push_back('0);
    #1;
    lit("reset_async_outputs", act, '0);
    lit("reset_ir_cleared", outs_t'(dut.ir_q), '0);
    @(posedge clk); #1;
    reset = 1'b0; run = 1'b0;
    expq.push_back('0);
    instr(16'h0005, 16'h0000, s_mv11);
    idle(2);
    @(posedge clk); #1;
    active = 1'b0;

    lit("idle_after_reset", hist[s_idle + 4], '0);
    lit("mvi_fetch", hist[s_mvi], rec(1, 4'b0, 4'b0, 0, 0, 0, 0, 0, 0, 0));
    lit("mvi_T1", hist[s_mvi + 1], rec(0, 4'b0010, 4'b0, 1, 0, 0, 0, 0, 1, 1));
    lit("mvi_busy_falls", hist[s_mvi + 2], '0);
    lit("add_T1", hist[s_add + 1], rec(0, 4'b0, 4'b0001, 0, 1, 0, 0, 0, 0, 1));
    lit("add_T2", hist[s_add + 2], rec(0, 4'b0, 4'b0010, 0, 0, 1, 0, 0, 0, 1));
    lit("add_T3", hist[s_add + 3], rec(0, 4'b0001, 4'b0, 0, 0, 0, 1, 0, 1, 1));
    lit("sub_T2", hist[s_sub + 2], rec(0, 4'b0, 4'b0100, 0, 0, 1, 0, 1, 0, 1));
    lit("b2b_refetch", hist[s_sub + 4], rec(1, 4'b0, 4'b0, 0, 0, 0, 0, 0, 0, 0));
    lit("mv_T1", hist[s_sub + 5], rec(0, 4'b0100, 4'b1000, 0, 0, 0, 0, 0, 1, 1));
    lit("b2b_six_cycles", hist[s_sub + 6], '0);
    lit("nop_T1", hist[s_nop + 1], rec(0, 4'b0, 4'b0, 0, 0, 0, 0, 0, 1, 1));
    lit("reset_abort_cycle", hist[s_rst + 2], '0);
    lit("mv_r1_r1", hist[s_mv11 + 1], rec(0, 4'b0010, 4'b0010, 0, 0, 0, 0, 0, 1, 1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
